transceiver_cal_sequencer: RTL and testbench
============================================

// Module: transceiver_cal_sequencer
// PURPOSE
// - Sequences physical-layer calibration from the link layer's i_sys_clk_120 domain.
// - Drives the cal-start request and evaluates cal-done / cal-fail.
// - Applies timeout, bounded retry with backoff, and retrain-on-demand; reports link-up / link-fail to link layer and monitor.
// - Sits between the link layer and the cal_start/done/fail synchronizers; all inputs arrive already synchronized.
// PARAMETERS
// - TIMEOUT_CYCLES  = 4096 : max cycles in any wait state (REQ, RELEASE) before the attempt is declared failed
// - MAX_RETRIES     = 3    : retries after the first failed attempt before FAILED
// - BACKOFF_CYCLES  = 256  : idle cycles between a failed attempt and the next request (>=1)
// PORTS
// - i_sys_clk_120   in   1   system clock
// - i_sys_rst       in   1   synchronous reset, active-high
// - i_enable        in   1   level; 1 = bring link up, 0 = take link down
// - i_retrain       in   1   pulse; restart calibration from LINKED or FAILED
// - i_link_lost     in   1   level from link layer; connection lost while linked
// - i_cal_done      in   1   synced physical cal done (4-phase ack)
// - i_cal_fail      in   1   synced physical cal fail (4-phase ack)
// - o_cal_start     out  1   registered cal request (4-phase req)
// - o_link_up       out  1   calibration succeeded, link usable
// - o_link_fail     out  1   sticky: retries exhausted
// - o_timeout       out  1   one-cycle pulse per timed-out attempt
// - o_retry_cnt     out  W_R retries used; W_R = $clog2(MAX_RETRIES+1)
// - o_state         out  3   current FSM state encoding (monitor)
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; counters 0. Reset mid-handshake drops o_cal_start the next edge.
// - Handshake (4-phase):
//   - o_cal_start rises and holds until done or fail is seen.
//   - It then falls; no new request until done and fail are both low.
// - FSM (state codes 0..5): IDLE, REQ, RELEASE, BACKOFF, LINKED, FAILED.
// - IDLE: i_enable=1 -> REQ; retry_cnt cleared.
// - REQ: o_cal_start=1; timer counts from 0.
//   - Exits to RELEASE, recording the result:
//     - i_cal_done -> result OK;
//     - else i_cal_fail -> result BAD;
//     - else timer == TIMEOUT_CYCLES-1 -> result BAD, o_timeout pulse.
//   - done and fail in the same cycle -> OK (done has priority).
// - RELEASE: o_cal_start=0; timer restarts; wait until done=0 and fail=0.
//   - Result OK -> LINKED.
//   - Result BAD and retry_cnt == MAX_RETRIES -> FAILED.
//   - Otherwise retry_cnt+1 and -> BACKOFF.
//   - Timeout in RELEASE -> FAILED, o_timeout pulse (peer stuck).
// - BACKOFF: counts BACKOFF_CYCLES, then -> REQ.
// - LINKED: o_link_up=1 (registered, set on the edge entering LINKED).
//   - i_retrain or i_link_lost -> REQ, with retry_cnt cleared and o_link_up cleared on the same edge.
// - FAILED: o_link_fail=1, held. i_retrain -> REQ with retry_cnt cleared and o_link_fail cleared.
// - i_enable=0 takes precedence in any state:
//   - from REQ/RELEASE -> RELEASE with an abort flag; completes the handshake, then -> IDLE;
//   - from all other states -> IDLE next edge.
//   - o_link_up and o_link_fail clear on the same edge.
// - i_retrain outside LINKED/FAILED: ignored.
// - Counters: timer width $clog2(TIMEOUT_CYCLES). No wrap; the timer saturates and is compared by equality. retry_cnt never exceeds MAX_RETRIES.
// - Latency: enable -> o_cal_start = 1 cycle. done -> o_cal_start low = 1 cycle. Release complete -> o_link_up = 1 cycle.
// STRUCTURE
// - Shared package/defines: state encodings (CAL_SEQ_IDLE..CAL_SEQ_FAILED, 3-bit) and default TIMEOUT/RETRY/BACKOFF values, in lvds_transceiver_defines.vh.
// - Single module with one FSM plus two counters (timer, retry); no sub-module.
// TESTING
// - Reset, enable=1, done asserted 20 cycles after o_cal_start and dropped 5 cycles after its fall:
//   o_cal_start high exactly 21 cycles; o_link_up=1 one cycle after done falls; retry_cnt=0.
// - MAX_RETRIES=3, fail every attempt: 4 requests, each separated by BACKOFF_CYCLES idle; then o_link_fail=1, retry_cnt=3, state FAILED.
// - No ack, TIMEOUT_CYCLES=64: o_timeout pulses at cycle 64 of REQ; o_cal_start falls; retry_cnt increments to 1.
// - done and fail asserted in the same cycle: treated as OK, o_link_up=1.
// - LINKED, then i_link_lost=1: o_link_up=0 next edge and o_cal_start=1; retry_cnt=0.
// - enable=0 while in REQ with done high: o_cal_start falls; FSM waits in RELEASE until done low; then IDLE with all outputs 0.
//   Repeat with i_sys_rst mid-REQ: o_cal_start=0 the next edge.

Source files
------------

// File: rtl/transceiver_cal_sequencer_pkg.sv
// Shared definitions for the transceiver calibration sequencer: state
// encodings, default timing/retry values and width helpers.
package transceiver_cal_sequencer_pkg;

  // Sequencer states; the encoding is exported on o_state for monitoring.
  typedef enum logic [2:0] {
    CAL_SEQ_IDLE    = 3'd0,
    CAL_SEQ_REQ     = 3'd1,
    CAL_SEQ_RELEASE = 3'd2,
    CAL_SEQ_BACKOFF = 3'd3,
    CAL_SEQ_LINKED  = 3'd4,
    CAL_SEQ_FAILED  = 3'd5
  } cal_seq_state_e;

  localparam int DEF_TIMEOUT_CYCLES = 32'sd4096;
  localparam int DEF_MAX_RETRIES    = 32'sd3;
  localparam int DEF_BACKOFF_CYCLES = 32'sd256;

  // Width of the retry counter; never narrower than one bit.
  function automatic int retry_width(input int max_retries);
    if (max_retries > 32'sd0) begin
      return $clog2(max_retries + 32'sd1);
    end else begin
      return 32'sd1;
    end
  endfunction

  // The single timer serves both wait-state timeouts and backoff, so it must
  // hold the larger of the two terminal values.
  function automatic int timer_width(input int timeout_cycles, input int backoff_cycles);
    int span;
    span = (timeout_cycles > backoff_cycles) ? timeout_cycles : backoff_cycles;
    if (span > 32'sd1) begin
      return $clog2(span);
    end else begin
      return 32'sd1;
    end
  endfunction

endpackage

// File: rtl/transceiver_cal_sequencer.sv
// Calibration sequencer: drives a 4-phase cal request toward the PHY,
// evaluates done/fail, and applies timeout, bounded retry with backoff and
// retrain-on-demand. All inputs arrive already synchronized to i_sys_clk_120.
module transceiver_cal_sequencer
  import transceiver_cal_sequencer_pkg::*;
#(
  parameter int  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int  MAX_RETRIES    = DEF_MAX_RETRIES,
  parameter int  BACKOFF_CYCLES = DEF_BACKOFF_CYCLES,
  localparam int W_R            = retry_width(MAX_RETRIES)
) (
  input  logic           i_sys_clk_120,
  input  logic           i_sys_rst,
  input  logic           i_enable,
  input  logic           i_retrain,
  input  logic           i_link_lost,
  input  logic           i_cal_done,
  input  logic           i_cal_fail,
  output logic           o_cal_start,
  output logic           o_link_up,
  output logic           o_link_fail,
  output logic           o_timeout,
  output logic [W_R-1:0] o_retry_cnt,
  output logic [2:0]     o_state
);

  localparam int TW = timer_width(TIMEOUT_CYCLES, BACKOFF_CYCLES);

  localparam logic [TW-1:0]  TIMER_ZERO   = {TW{1'b0}};
  localparam logic [TW-1:0]  TIMER_ONE    = TW'(1);
  localparam logic [TW-1:0]  TIMER_MAX    = {TW{1'b1}};
  localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]  BACKOFF_LAST = TW'(BACKOFF_CYCLES - 1);
  localparam logic [W_R-1:0] RETRY_ZERO   = {W_R{1'b0}};
  localparam logic [W_R-1:0] RETRY_ONE    = W_R'(1);
  localparam logic [W_R-1:0] RETRY_MAX    = W_R'(MAX_RETRIES);

  cal_seq_state_e state_r;
  logic [TW-1:0]  timer_r;
  logic [TW-1:0]  timer_inc_s;
  logic [W_R-1:0] retry_cnt_r;
  logic           result_ok_r;
  logic           abort_r;
  logic           abort_s;
  logic           acks_low_s;
  logic           cal_start_r;
  logic           link_up_r;
  logic           link_fail_r;
  logic           timeout_r;

  // The handshake may only complete once the PHY has withdrawn both acks.
  assign acks_low_s = ~i_cal_done & ~i_cal_fail;

  // A disable seen at any point during release turns it into an abort.
  assign abort_s = abort_r | ~i_enable;

  // Saturating timer increment; the timer is only ever compared by equality.
  always_comb begin
    timer_inc_s = timer_r;
    if (timer_r == TIMER_MAX) begin
      timer_inc_s = timer_r;
    end else begin
      timer_inc_s = timer_r + TIMER_ONE;
    end
  end

  // Sequencer FSM with its timer, retry counter and registered outputs.
  always_ff @(posedge i_sys_clk_120) begin
    if (i_sys_rst) begin
      state_r     <= CAL_SEQ_IDLE;
      timer_r     <= TIMER_ZERO;
      retry_cnt_r <= RETRY_ZERO;
      result_ok_r <= 1'b0;
      abort_r     <= 1'b0;
      cal_start_r <= 1'b0;
      link_up_r   <= 1'b0;
      link_fail_r <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        CAL_SEQ_IDLE: begin
          retry_cnt_r <= RETRY_ZERO;
          abort_r     <= 1'b0;
          if (i_enable) begin
            state_r     <= CAL_SEQ_REQ;
            cal_start_r <= 1'b1;
            timer_r     <= TIMER_ZERO;
            result_ok_r <= 1'b0;
          end else begin
            state_r <= CAL_SEQ_IDLE;
          end
        end

        CAL_SEQ_REQ: begin
          if (!i_enable) begin
            state_r     <= CAL_SEQ_RELEASE;
            abort_r     <= 1'b1;
            cal_start_r <= 1'b0;
            timer_r     <= TIMER_ZERO;
          end else if (i_cal_done) begin
            // done wins over a simultaneous fail
            state_r     <= CAL_SEQ_RELEASE;
            result_ok_r <= 1'b1;
            cal_start_r <= 1'b0;
            timer_r     <= TIMER_ZERO;
          end else if (i_cal_fail) begin
            state_r     <= CAL_SEQ_RELEASE;
            result_ok_r <= 1'b0;
            cal_start_r <= 1'b0;
            timer_r     <= TIMER_ZERO;
          end else if (timer_r == TIMEOUT_LAST) begin
            state_r     <= CAL_SEQ_RELEASE;
            result_ok_r <= 1'b0;
            cal_start_r <= 1'b0;
            timer_r     <= TIMER_ZERO;
            timeout_r   <= 1'b1;
          end else begin
            timer_r <= timer_inc_s;
          end
        end

        CAL_SEQ_RELEASE: begin
          if (acks_low_s) begin
            timer_r <= TIMER_ZERO;
            abort_r <= 1'b0;
            if (abort_s) begin
              state_r     <= CAL_SEQ_IDLE;
              retry_cnt_r <= RETRY_ZERO;
            end else if (result_ok_r) begin
              state_r   <= CAL_SEQ_LINKED;
              link_up_r <= 1'b1;
            end else if (retry_cnt_r == RETRY_MAX) begin
              state_r     <= CAL_SEQ_FAILED;
              link_fail_r <= 1'b1;
            end else begin
              state_r     <= CAL_SEQ_BACKOFF;
              retry_cnt_r <= retry_cnt_r + RETRY_ONE;
            end
          end else if (timer_r == TIMEOUT_LAST) begin
            // Peer never withdrew its ack.
            timer_r   <= TIMER_ZERO;
            timeout_r <= 1'b1;
            abort_r   <= 1'b0;
            if (abort_s) begin
              state_r     <= CAL_SEQ_IDLE;
              retry_cnt_r <= RETRY_ZERO;
            end else begin
              state_r     <= CAL_SEQ_FAILED;
              link_fail_r <= 1'b1;
            end
          end else begin
            timer_r <= timer_inc_s;
            abort_r <= abort_s;
          end
        end

        CAL_SEQ_BACKOFF: begin
          if (!i_enable) begin
            state_r     <= CAL_SEQ_IDLE;
            retry_cnt_r <= RETRY_ZERO;
            timer_r     <= TIMER_ZERO;
          end else if (timer_r == BACKOFF_LAST) begin
            state_r     <= CAL_SEQ_REQ;
            cal_start_r <= 1'b1;
            result_ok_r <= 1'b0;
            timer_r     <= TIMER_ZERO;
          end else begin
            timer_r <= timer_inc_s;
          end
        end

        CAL_SEQ_LINKED: begin
          if (!i_enable) begin
            state_r     <= CAL_SEQ_IDLE;
            link_up_r   <= 1'b0;
            retry_cnt_r <= RETRY_ZERO;
          end else if (i_retrain || i_link_lost) begin
            state_r     <= CAL_SEQ_REQ;
            link_up_r   <= 1'b0;
            cal_start_r <= 1'b1;
            retry_cnt_r <= RETRY_ZERO;
            result_ok_r <= 1'b0;
            timer_r     <= TIMER_ZERO;
          end else begin
            state_r <= CAL_SEQ_LINKED;
          end
        end

        CAL_SEQ_FAILED: begin
          if (!i_enable) begin
            state_r     <= CAL_SEQ_IDLE;
            link_fail_r <= 1'b0;
            retry_cnt_r <= RETRY_ZERO;
          end else if (i_retrain) begin
            state_r     <= CAL_SEQ_REQ;
            link_fail_r <= 1'b0;
            cal_start_r <= 1'b1;
            retry_cnt_r <= RETRY_ZERO;
            result_ok_r <= 1'b0;
            timer_r     <= TIMER_ZERO;
          end else begin
            state_r <= CAL_SEQ_FAILED;
          end
        end

        default: begin
          state_r     <= CAL_SEQ_IDLE;
          timer_r     <= TIMER_ZERO;
          retry_cnt_r <= RETRY_ZERO;
          result_ok_r <= 1'b0;
          abort_r     <= 1'b0;
          cal_start_r <= 1'b0;
          link_up_r   <= 1'b0;
          link_fail_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_cal_start = cal_start_r;
  assign o_link_up   = link_up_r;
  assign o_link_fail = link_fail_r;
  assign o_timeout   = timeout_r;
  assign o_retry_cnt = retry_cnt_r;
  assign o_state     = state_r;

endmodule

// File: tb/tb_transceiver_cal_sequencer.sv
// Directed self-checking bench for transceiver_cal_sequencer.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_transceiver_cal_sequencer;

  localparam int TO  = 64;
  localparam int MR  = 3;
  localparam int BO  = 8;
  localparam int W_R = 2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_REL  = 3'd2;
  localparam logic [2:0] S_BO   = 3'd3;
  localparam logic [2:0] S_LNK  = 3'd4;
  localparam logic [2:0] S_FAIL = 3'd5;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic           retrain;
  logic           link_lost;
  logic           cal_done;
  logic           cal_fail;
  logic           cal_start;
  logic           link_up;
  logic           link_fail;
  logic           timeout;
  logic [W_R-1:0] retry_cnt;
  logic [2:0]     state;

  int checks = 0;
  int errors = 0;

  transceiver_cal_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRIES   (MR),
    .BACKOFF_CYCLES(BO)
  ) dut (
    .i_sys_clk_120(clk),
    .i_sys_rst    (rst),
    .i_enable     (enable),
    .i_retrain    (retrain),
    .i_link_lost  (link_lost),
    .i_cal_done   (cal_done),
    .i_cal_fail   (cal_fail),
    .o_cal_start  (cal_start),
    .o_link_up    (link_up),
    .o_link_fail  (link_fail),
    .o_timeout    (timeout),
    .o_retry_cnt  (retry_cnt),
    .o_state      (state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Wait (bounded) until o_cal_start reaches lvl; an expired bound fails the check.
  task automatic wait_start(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (cal_start !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, {31'd0, cal_start}, {31'd0, lvl});
  endtask

  initial begin
    int hi;
    int to_seen;
    int bo;
    int reqs;
    int n;

    rst = 1'b1; enable = 1'b0; retrain = 1'b0; link_lost = 1'b0;
    cal_done = 1'b0; cal_fail = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_state",     {29'd0, state},     {29'd0, S_IDLE});
    check_eq("rst_cal_start", {31'd0, cal_start}, 32'd0);
    check_eq("rst_link_up",   {31'd0, link_up},   32'd0);
    check_eq("rst_link_fail", {31'd0, link_fail}, 32'd0);
    check_eq("rst_timeout",   {31'd0, timeout},   32'd0);
    check_eq("rst_retry",     {30'd0, retry_cnt}, 32'd0);
    rst = 1'b0;

    // Retrain is ignored outside LINKED/FAILED.
    retrain = 1'b1;
    @(negedge clk);
    retrain = 1'b0;
    check_eq("retrain_idle", {29'd0, state}, {29'd0, S_IDLE});

    // Basic bring-up: done 20 cycles after request, dropped 5 cycles after release.
    enable = 1'b1;
    @(negedge clk);
    check_eq("en_latency", {31'd0, cal_start}, 32'd1);
    hi = 0;
    while (cal_start === 1'b1 && hi < 100) begin
      hi++;
      if (hi == 21) cal_done = 1'b1;
      @(negedge clk);
    end
    check_eq("start_hi_cycles", hi, 32'd21);
    repeat (5) @(negedge clk);
    check_eq("rel_wait_state", {29'd0, state},   {29'd0, S_REL});
    check_eq("rel_wait_lnk",   {31'd0, link_up}, 32'd0);
    cal_done = 1'b0;
    @(negedge clk);
    check_eq("link_up",     {31'd0, link_up},   32'd1);
    check_eq("lnk_state",   {29'd0, state},     {29'd0, S_LNK});
    check_eq("lnk_retry",   {30'd0, retry_cnt}, 32'd0);

    // Link lost while linked: immediate re-request.
    link_lost = 1'b1;
    @(negedge clk);
    link_lost = 1'b0;
    check_eq("lost_link_up", {31'd0, link_up},   32'd0);
    check_eq("lost_start",   {31'd0, cal_start}, 32'd1);
    check_eq("lost_retry",   {30'd0, retry_cnt}, 32'd0);
    check_eq("lost_state",   {29'd0, state},     {29'd0, S_REQ});

    // done and fail together count as success.
    cal_done = 1'b1; cal_fail = 1'b1;
    @(negedge clk);
    check_eq("both_start", {31'd0, cal_start}, 32'd0);
    check_eq("both_state", {29'd0, state},     {29'd0, S_REL});
    cal_done = 1'b0; cal_fail = 1'b0;
    @(negedge clk);
    check_eq("both_link_up", {31'd0, link_up}, 32'd1);

    // Retrain from LINKED, then disable mid-request with done high.
    retrain = 1'b1;
    @(negedge clk);
    retrain = 1'b0;
    check_eq("retrain_state", {29'd0, state}, {29'd0, S_REQ});
    cal_done = 1'b1; enable = 1'b0;
    @(negedge clk);
    check_eq("abort_start", {31'd0, cal_start}, 32'd0);
    repeat (3) @(negedge clk);
    check_eq("abort_hold", {29'd0, state}, {29'd0, S_REL});
    cal_done = 1'b0;
    @(negedge clk);
    check_eq("abort_idle",      {29'd0, state},     {29'd0, S_IDLE});
    check_eq("abort_start_0",   {31'd0, cal_start}, 32'd0);
    check_eq("abort_link_up",   {31'd0, link_up},   32'd0);
    check_eq("abort_link_fail", {31'd0, link_fail}, 32'd0);
    check_eq("abort_retry",     {30'd0, retry_cnt}, 32'd0);

    // Reset in the middle of a request.
    enable = 1'b1;
    @(negedge clk);
    check_eq("rq2_start", {31'd0, cal_start}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_start", {31'd0, cal_start}, 32'd0);
    check_eq("mid_rst_state", {29'd0, state},     {29'd0, S_IDLE});
    rst = 1'b0;

    // No acknowledge: timeout after TO cycles in REQ.
    wait_start(1'b1, 10, "to_rise");
    hi = 0; to_seen = 0;
    while (cal_start === 1'b1 && hi < 200) begin
      hi++;
      if (timeout === 1'b1) to_seen++;
      @(negedge clk);
    end
    check_eq("to_hi_cycles", hi,                  TO);
    check_eq("to_early",     to_seen,             32'd0);
    check_eq("to_pulse",     {31'd0, timeout},    32'd1);
    @(negedge clk);
    check_eq("to_pulse_end", {31'd0, timeout},    32'd0);
    check_eq("to_retry",     {30'd0, retry_cnt},  32'd1);
    check_eq("to_backoff",   {29'd0, state},      {29'd0, S_BO});
    enable = 1'b0;
    @(negedge clk);
    check_eq("to_dis_idle",  {29'd0, state},     {29'd0, S_IDLE});
    check_eq("to_dis_retry", {30'd0, retry_cnt}, 32'd0);

    // Every attempt fails: MR+1 requests separated by BO backoff cycles.
    enable = 1'b1;
    reqs = 0;
    for (int a = 0; a <= MR; a++) begin
      wait_start(1'b1, 50, "rt_rise");
      reqs++;
      cal_fail = 1'b1;
      wait_start(1'b0, 10, "rt_fall");
      cal_fail = 1'b0;
      bo = 0; n = 0;
      do begin
        @(negedge clk);
        n++;
        if (state === S_BO) bo++;
      end while (cal_start !== 1'b1 && state !== S_FAIL && n < 50);
      if (a < MR) begin
        check_eq("rt_backoff", bo, BO);
        check_eq("rt_retry",   {30'd0, retry_cnt}, a + 1);
      end
    end
    check_eq("rt_reqs",      reqs,                MR + 1);
    check_eq("rt_link_fail", {31'd0, link_fail},  32'd1);
    check_eq("rt_retry_max", {30'd0, retry_cnt},  MR);
    check_eq("rt_state",     {29'd0, state},      {29'd0, S_FAIL});
    repeat (3) @(negedge clk);
    check_eq("rt_sticky",    {31'd0, link_fail},  32'd1);

    // Retrain from FAILED restarts cleanly.
    retrain = 1'b1;
    @(negedge clk);
    retrain = 1'b0;
    check_eq("rf_link_fail", {31'd0, link_fail}, 32'd0);
    check_eq("rf_start",     {31'd0, cal_start}, 32'd1);
    check_eq("rf_retry",     {30'd0, retry_cnt}, 32'd0);
    cal_done = 1'b1;
    wait_start(1'b0, 10, "rf_fall");
    cal_done = 1'b0;
    @(negedge clk);
    check_eq("rf_link_up", {31'd0, link_up}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
